// File: rtl/fol_ctrl_pkg.sv
// Shared types and constants for the first-order low-pass filter sequencing controller.
package fol_ctrl_pkg;

  localparam int unsigned COEF_W = 16;
  localparam int unsigned OUT_W  = 32;
  localparam logic [COEF_W-1:0] A0_ONE = 16'h8000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPrime = 2'd1,
    StRun   = 2'd2,
    StRamp  = 2'd3
  } fol_state_e;

  // Move cur toward tgt by at most max_step without overshooting.
  function automatic logic [COEF_W-1:0] ramp_step(input logic [COEF_W-1:0] cur,
                                                  input logic [COEF_W-1:0] tgt,
                                                  input logic signed [COEF_W:0] max_step);
    logic signed [COEF_W:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > max_step) begin
      return cur + max_step[COEF_W-1:0];
    end else if (diff < -max_step) begin
      return cur - max_step[COEF_W-1:0];
    end
    return tgt;
  endfunction

endpackage

// File: rtl/fol_filter_ctrl_if.sv
// Bus bundle between the filter controller and its sample source, config bus and filter core.
interface fol_filter_ctrl_if;
  import fol_ctrl_pkg::*;

  logic                     i_enable;
  logic                     i_cfg_valid;
  logic                     o_cfg_ready;
  logic [COEF_W-1:0]        i_cfg_a0;
  logic                     o_cfg_err;
  logic                     i_sample_valid;
  logic signed [COEF_W-1:0] i_sample;
  logic [COEF_W-1:0]        o_core_a0;
  logic signed [COEF_W-1:0] o_core_x;
  logic signed [OUT_W-1:0]  i_core_y;
  logic                     o_y_valid;
  logic signed [OUT_W-1:0]  o_y;
  logic                     o_busy;
  logic                     o_settled;
  logic [1:0]               o_state;

  modport master (
    input  i_enable, i_cfg_valid, i_cfg_a0, i_sample_valid, i_sample, i_core_y,
    output o_cfg_ready, o_cfg_err, o_core_a0, o_core_x, o_y_valid, o_y, o_busy, o_settled,
           o_state
  );

  modport slave (
    output i_enable, i_cfg_valid, i_cfg_a0, i_sample_valid, i_sample, i_core_y,
    input  o_cfg_ready, o_cfg_err, o_core_a0, o_core_x, o_y_valid, o_y, o_busy, o_settled,
           o_state
  );

endinterface

// File: rtl/fol_settle_mon.sv
// Settle monitor: counts consecutive valid outputs whose step from the previous one is small.
module fol_settle_mon
  import fol_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_TOL = 16,
  parameter int unsigned SETTLE_CNT = 64
) (
  input  logic                    i_clkp,
  input  logic                    i_rstn,
  input  logic                    i_clr,
  input  logic                    i_valid,
  input  logic signed [OUT_W-1:0] i_y,
  output logic                    o_settled
);

  localparam int unsigned CntW = $clog2(SETTLE_CNT + 1);

  logic signed [OUT_W-1:0] prev_q, prev_d;
  logic                    have_prev_q, have_prev_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [OUT_W:0]          diff, abs_diff;
  logic                    quiet;

  // Sign-extended 33-bit difference cannot wrap for any pair of 32-bit inputs.
  always_comb begin
    diff     = {i_y[OUT_W-1], i_y} - {prev_q[OUT_W-1], prev_q};
    abs_diff = diff[OUT_W] ? (~diff + 33'd1) : diff;
    quiet    = abs_diff <= 33'(SETTLE_TOL);
  end

  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    cnt_d       = cnt_q;
    if (i_clr) begin
      have_prev_d = 1'b0;
      cnt_d       = '0;
    end else if (i_valid) begin
      prev_d      = i_y;
      have_prev_d = 1'b1;
      if (have_prev_q) begin
        if (!quiet) begin
          cnt_d = '0;
        end else if (cnt_q < CntW'(SETTLE_CNT)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clkp or negedge i_rstn) begin
    if (!i_rstn) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_settled = cnt_q >= CntW'(SETTLE_CNT);

endmodule

// File: rtl/fol_filter_ctrl.sv
// Sequencing controller for the first-order low-pass core: priming, coefficient ramping,
// output valid tagging and settle reporting.
module fol_filter_ctrl
  import fol_ctrl_pkg::*;
#(
  parameter int unsigned LAT        = 4,
  parameter int unsigned RAMP_STEP  = 256,
  parameter int unsigned RAMP_DIV   = 8,
  parameter int unsigned PRIME_CYC  = 8,
  parameter int unsigned SETTLE_TOL = 16,
  parameter int unsigned SETTLE_CNT = 64
) (
  input  logic              i_clkp,
  input  logic              i_rstn,
  fol_filter_ctrl_if.master bus
);

  localparam int unsigned DivW   = $clog2(RAMP_DIV + 1);
  localparam int unsigned PrimeW = $clog2(PRIME_CYC + 1);

  fol_state_e               state_q, state_d;
  logic [COEF_W-1:0]        target_q, target_d;
  logic [COEF_W-1:0]        cur_q, cur_d;
  logic [COEF_W-1:0]        core_a0_q, core_a0_d;
  logic signed [COEF_W-1:0] core_x_q, core_x_d;
  logic                     cfg_ready_q, cfg_ready_d;
  logic                     cfg_err_q, cfg_err_d;
  logic [DivW-1:0]          div_cnt_q, div_cnt_d;
  logic [PrimeW-1:0]        prime_cnt_q, prime_cnt_d;
  logic                     strobe_q, strobe_d;
  logic [LAT-1:0]           vpipe_q, vpipe_d;
  logic                     y_valid_q, y_valid_d;
  logic signed [OUT_W-1:0]  y_q;

  logic              accept, legal, ramp_tick, settle_clr;
  logic [COEF_W-1:0] cur_step;

  assign accept    = bus.i_cfg_valid & cfg_ready_q;
  assign legal     = bus.i_cfg_a0 <= A0_ONE;
  assign ramp_tick = div_cnt_q == DivW'(RAMP_DIV - 1);
  assign cur_step  = ramp_step(cur_q, target_q, (COEF_W + 1)'(RAMP_STEP));

  always_ff @(posedge i_clkp or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.i_enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (bus.i_sample_valid) state_d = StPrime;
        StPrime: if (prime_cnt_q == PrimeW'(PRIME_CYC - 1)) state_d = StRun;
        StRun:   if (accept && legal && (bus.i_cfg_a0 != cur_q)) state_d = StRamp;
        StRamp:  if (ramp_tick && (cur_step == target_q)) state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    target_d    = target_q;
    cur_d       = cur_q;
    cfg_err_d   = cfg_err_q;
    div_cnt_d   = '0;
    prime_cnt_d = '0;

    // Illegal requests still complete the handshake; only the error flag records them.
    if (accept) begin
      cfg_err_d = !legal;
      if (legal) target_d = bus.i_cfg_a0;
    end

    if ((state_q == StPrime) && (state_d == StRun)) begin
      cur_d = target_q;
    end else if ((state_q == StRamp) && (state_d != StIdle) && ramp_tick) begin
      cur_d = cur_step;
    end

    if ((state_d == StRamp) && (state_q == StRamp) && !ramp_tick) begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
    if ((state_d == StPrime) && (state_q == StPrime)) begin
      prime_cnt_d = prime_cnt_q + 1'b1;
    end

    unique case (state_d)
      StIdle:  core_a0_d = '0;
      StPrime: core_a0_d = A0_ONE;
      default: core_a0_d = cur_d;
    endcase

    if (state_d == StIdle) begin
      core_x_d = '0;
    end else if (bus.i_sample_valid) begin
      core_x_d = bus.i_sample;
    end else begin
      core_x_d = core_x_q;
    end

    cfg_ready_d = (state_d == StIdle) || (state_d == StRun);
    // Only strobes taken while running are tagged; priming samples stay untagged.
    strobe_d    = bus.i_sample_valid && bus.i_enable &&
                  ((state_q == StRun) || (state_q == StRamp));
    vpipe_d     = (state_d == StIdle) ? '0 : LAT'({vpipe_q, strobe_q});
    y_valid_d   = (state_d != StIdle) && vpipe_q[LAT-1];
    settle_clr  = !bus.i_enable ||
                  ((state_d != state_q) && ((state_d == StRamp) || (state_d == StPrime)));
  end

  always_ff @(posedge i_clkp or negedge i_rstn) begin
    if (!i_rstn) begin
      target_q    <= '0;
      cur_q       <= '0;
      core_a0_q   <= '0;
      core_x_q    <= '0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      div_cnt_q   <= '0;
      prime_cnt_q <= '0;
      strobe_q    <= 1'b0;
      vpipe_q     <= '0;
      y_valid_q   <= 1'b0;
      y_q         <= '0;
    end else begin
      target_q    <= target_d;
      cur_q       <= cur_d;
      core_a0_q   <= core_a0_d;
      core_x_q    <= core_x_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      div_cnt_q   <= div_cnt_d;
      prime_cnt_q <= prime_cnt_d;
      strobe_q    <= strobe_d;
      vpipe_q     <= vpipe_d;
      y_valid_q   <= y_valid_d;
      y_q         <= bus.i_core_y;
    end
  end

  fol_settle_mon #(
    .SETTLE_TOL (SETTLE_TOL),
    .SETTLE_CNT (SETTLE_CNT)
  ) u_settle_mon (
    .i_clkp    (i_clkp),
    .i_rstn    (i_rstn),
    .i_clr     (settle_clr),
    .i_valid   (y_valid_q),
    .i_y       (y_q),
    .o_settled (bus.o_settled)
  );

  assign bus.o_cfg_ready = cfg_ready_q;
  assign bus.o_cfg_err   = cfg_err_q;
  assign bus.o_core_a0   = core_a0_q;
  assign bus.o_core_x    = core_x_q;
  assign bus.o_y_valid   = y_valid_q;
  assign bus.o_y         = y_q;
  assign bus.o_busy      = state_q != StRun;
  assign bus.o_state     = state_q;

endmodule

// File: tb/tb_fol_filter_ctrl.sv
// Directed bench for fol_filter_ctrl with a behavioural LAT-cycle filter core model.
module tb_fol_filter_ctrl;

  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rstn;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   nvalid;

  logic signed [31:0] core_pipe [LAT] = '{default: '0};
  logic signed [31:0] y_off;
  logic signed [63:0] core_next;

  fol_filter_ctrl_if bus ();

  fol_filter_ctrl #(
    .LAT        (LAT),
    .RAMP_STEP  (256),
    .RAMP_DIV   (8),
    .PRIME_CYC  (8),
    .SETTLE_TOL (16),
    .SETTLE_CNT (64)
  ) dut (
    .i_clkp (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Core: y(n) = (a0*x + (32768-a0)*y(n-1)) >> 15, visible LAT cycles after x/a0 register.
  assign core_next = (64'(bus.o_core_a0) * 64'(bus.o_core_x) +
                      (64'sd32768 - 64'(bus.o_core_a0)) * 64'(core_pipe[0])) >>> 15;

  always @(posedge clk) begin
    core_pipe[0] <= 32'(core_next);
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end

  assign bus.i_core_y = core_pipe[LAT-1] + y_off;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_req(input logic [15:0] a0);
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg_a0    = a0;
    waitn(1);
    bus.i_cfg_valid = 1'b0;
  endtask

  initial begin
    rstn               = 1'b1;
    y_off              = '0;
    bus.i_enable       = 1'b0;
    bus.i_cfg_valid    = 1'b0;
    bus.i_cfg_a0       = '0;
    bus.i_sample_valid = 1'b0;
    bus.i_sample       = '0;
    #1 rstn = 1'b0;
    #3;
    chk("rst_state", 64'(bus.o_state), 0);
    chk("rst_a0", 64'(bus.o_core_a0), 0);
    chk("rst_x", 64'(bus.o_core_x), 0);
    chk("rst_ready", 64'(bus.o_cfg_ready), 0);
    chk("rst_err", 64'(bus.o_cfg_err), 0);
    chk("rst_busy", 64'(bus.o_busy), 1);
    chk("rst_settled", 64'(bus.o_settled), 0);
    chk("rst_yvalid", 64'(bus.o_y_valid), 0);

    waitn(2);
    rstn = 1'b1;
    waitn(1);
    chk("idle_ready", 64'(bus.o_cfg_ready), 1);
    chk("idle_state", 64'(bus.o_state), 0);

    // Prime with 1000, target 0
    bus.i_enable       = 1'b1;
    bus.i_sample_valid = 1'b1;
    bus.i_sample       = 16'sd1000;
    waitn(1);
    bus.i_sample_valid = 1'b0;
    chk("prime_x", 64'(bus.o_core_x), 1000);
    for (int i = 0; i < 8; i++) begin
      chk("prime_state", 64'(bus.o_state), 1);
      chk("prime_a0", 64'(bus.o_core_a0), 32768);
      chk("prime_noval", 64'(bus.o_y_valid), 0);
      waitn(1);
    end
    chk("run_state", 64'(bus.o_state), 2);
    chk("run_a0", 64'(bus.o_core_a0), 0);
    chk("run_busy", 64'(bus.o_busy), 0);
    chk("primed_y", 64'(bus.o_y), 1000);

    // Ramp 0 -> 1024
    cfg_req(16'd1024);
    chk("ramp_state", 64'(bus.o_state), 3);
    chk("ramp_ready", 64'(bus.o_cfg_ready), 0);
    waitn(7);
    chk("ramp_pre", 64'(bus.o_core_a0), 0);
    waitn(1);
    chk("ramp_256", 64'(bus.o_core_a0), 256);
    waitn(8);
    chk("ramp_512", 64'(bus.o_core_a0), 512);
    waitn(8);
    chk("ramp_768", 64'(bus.o_core_a0), 768);
    chk("ramp_mid_state", 64'(bus.o_state), 3);
    waitn(8);
    chk("ramp_1024", 64'(bus.o_core_a0), 1024);
    chk("ramp_done_state", 64'(bus.o_state), 2);
    chk("ramp_done_ready", 64'(bus.o_cfg_ready), 1);

    // Out-of-range request, then legal one clears the error
    cfg_req(16'd40000);
    chk("err_set", 64'(bus.o_cfg_err), 1);
    chk("err_state", 64'(bus.o_state), 2);
    chk("err_a0", 64'(bus.o_core_a0), 1024);
    cfg_req(16'd100);
    chk("err_clr", 64'(bus.o_cfg_err), 0);
    chk("down_state", 64'(bus.o_state), 3);
    waitn(32);
    chk("down_a0", 64'(bus.o_core_a0), 100);
    chk("down_state_run", 64'(bus.o_state), 2);

    // Enable drop mid-ramp, then re-enable keeps target 2000
    cfg_req(16'd2000);
    waitn(8);
    chk("up_first", 64'(bus.o_core_a0), 356);
    bus.i_enable = 1'b0;
    waitn(1);
    chk("drop_state", 64'(bus.o_state), 0);
    chk("drop_a0", 64'(bus.o_core_a0), 0);
    chk("drop_x", 64'(bus.o_core_x), 0);
    chk("drop_settled", 64'(bus.o_settled), 0);
    bus.i_enable       = 1'b1;
    bus.i_sample_valid = 1'b1;
    waitn(1);
    bus.i_sample_valid = 1'b0;
    waitn(8);
    chk("reen_state", 64'(bus.o_state), 2);
    chk("reen_a0", 64'(bus.o_core_a0), 2000);

    // Set a0=16384 from IDLE, prime with 5000
    bus.i_enable = 1'b0;
    waitn(1);
    cfg_req(16'd16384);
    chk("idle_cfg_state", 64'(bus.o_state), 0);
    bus.i_enable       = 1'b1;
    bus.i_sample_valid = 1'b1;
    bus.i_sample       = 16'sd5000;
    waitn(1);
    bus.i_sample_valid = 1'b0;
    waitn(8);
    chk("a0_16384", 64'(bus.o_core_a0), 16384);

    // Single strobe: valid exactly LAT+1 edges later
    bus.i_sample_valid = 1'b1;
    waitn(1);
    bus.i_sample_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("val_early", 64'(bus.o_y_valid), 0);
      waitn(1);
    end
    chk("val_rise", 64'(bus.o_y_valid), 1);
    chk("val_y", 64'(bus.o_y), 5000);
    waitn(1);
    chk("val_fall", 64'(bus.o_y_valid), 0);

    // Continuous strobes until the settle flag rises
    nvalid             = 1;
    bus.i_sample_valid = 1'b1;
    for (int i = 0; i < 300 && nvalid < 66; i++) begin
      waitn(1);
      if (bus.o_y_valid) begin
        nvalid++;
        if (nvalid == 65) chk("settle_before", 64'(bus.o_settled), 0);
        if (nvalid == 66) chk("settle_after", 64'(bus.o_settled), 1);
      end
    end
    chk("settle_count", 64'(nvalid), 66);
    y_off = 32'sd16;
    waitn(3);
    chk("tol_edge", 64'(bus.o_settled), 1);
    y_off = 32'sd33;
    waitn(3);
    chk("tol_over", 64'(bus.o_settled), 0);
    chk("tol_y", 64'(bus.o_y), 5033);

    // Asynchronous reset mid-prime
    bus.i_sample_valid = 1'b0;
    bus.i_enable       = 1'b0;
    waitn(1);
    bus.i_enable       = 1'b1;
    bus.i_sample_valid = 1'b1;
    bus.i_sample       = 16'sd7000;
    waitn(1);
    bus.i_sample_valid = 1'b0;
    waitn(2);
    chk("prime_mid", 64'(bus.o_state), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_state", 64'(bus.o_state), 0);
    chk("arst_a0", 64'(bus.o_core_a0), 0);
    chk("arst_x", 64'(bus.o_core_x), 0);
    chk("arst_y", 64'(bus.o_y), 0);
    chk("arst_ready", 64'(bus.o_cfg_ready), 0);
    chk("arst_busy", 64'(bus.o_busy), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
